// File: rtl/iq_demod_pkg.sv
// ============================================================================
// Module  : iq_demod_pkg
// Brief   : Shared types, LO constants and the multiplier-free LO mixing helper
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package iq_demod_pkg;

  typedef logic signed [1:0] lo_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACC  = 1'b1
  } mix_state_t;

  localparam lo_t LO_POS  = 2'sb01;
  localparam lo_t LO_ZERO = 2'sb00;
  localparam lo_t LO_NEG  = 2'sb11;

  // Callers sign-extend into and truncate out of this fixed width
  localparam int MULT_W = 32;

  // Pass, negate or zero; the unused LO code -2 falls through to zero
  function automatic logic signed [MULT_W-1:0] lo_mult(
    input logic signed [MULT_W-1:0] sample,
    input lo_t                      lo
  );
    logic signed [MULT_W-1:0] r_prod;
    r_prod = '0;
    case (lo)
      LO_POS:  r_prod = sample;
      LO_NEG:  r_prod = -sample;
      default: r_prod = '0;
    endcase
    return r_prod;
  endfunction

endpackage

`default_nettype wire

// File: rtl/iq_mac_lane.sv
// ============================================================================
// Module  : iq_mac_lane
// Brief   : One mixer lane: LO product, window accumulator, dump narrowing.
//           Narrowing saturates when IQ_MIXER_SAT_EN is defined, else wraps.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module iq_mac_lane
  import iq_demod_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ACC_LEN = 16,
  parameter int OUT_W   = 12
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     i_clear,
  input  logic                     i_accept,
  input  logic                     i_last,
  input  logic                     i_load,
  input  logic signed [DATA_W-1:0] i_sample,
  input  lo_t                      i_lo,
  output logic signed [OUT_W-1:0]  o_result
);

  localparam int ACC_W = DATA_W + $clog2(ACC_LEN);
  // One guard bit so a full window of most-negative samples times -1 fits
  localparam int SUM_W = ACC_W + 1;

  logic signed [SUM_W-1:0] r_acc;
  logic signed [SUM_W-1:0] w_prod;
  logic signed [SUM_W-1:0] w_sum;
  logic signed [OUT_W-1:0] w_narrow;
  logic signed [OUT_W-1:0] r_result;

  assign w_prod = SUM_W'(lo_mult(MULT_W'(i_sample), i_lo));
  assign w_sum  = r_acc + w_prod;

`ifdef IQ_MIXER_SAT_EN
  localparam logic signed [SUM_W-1:0] c_max = {{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] c_min = {{(SUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  always_comb begin
    w_narrow = w_sum[OUT_W-1:0];
    if (w_sum > c_max)
      w_narrow = c_max[OUT_W-1:0];
    else if (w_sum < c_min)
      w_narrow = c_min[OUT_W-1:0];
  end
`else
  always_comb begin
    w_narrow = w_sum[OUT_W-1:0];
  end
`endif

  always_ff @(posedge clk) begin
    if (resetn)
      r_acc <= '0;
    else if (i_clear)
      r_acc <= '0;
    else if (i_accept)
      r_acc <= i_last ? '0 : w_sum;
  end

  always_ff @(posedge clk) begin
    if (resetn)
      r_result <= '0;
    else if (i_load)
      r_result <= w_narrow;
  end

  assign o_result = r_result;

endmodule

`default_nettype wire

// File: rtl/iq_mixer_acc.sv
// ============================================================================
// Module  : iq_mixer_acc
// Brief   : Quadrature mixer with integrate-and-dump and held-result handshake.
//           Optional macro IQ_MIXER_SAT_EN selects saturating output narrowing.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module iq_mixer_acc
  import iq_demod_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ACC_LEN = 16,
  parameter int OUT_W   = 12
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     enable,
  input  logic signed [DATA_W-1:0] in_sample,
  input  logic                     in_valid,
  input  logic signed [1:0]        lo_cos,
  input  logic signed [1:0]        lo_sin,
  output logic signed [OUT_W-1:0]  i_out,
  output logic signed [OUT_W-1:0]  q_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     overrun,
  output logic                     lo_err
);

  localparam int  CNT_W  = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam lo_t c_lo_bad = 2'sb10;

  mix_state_t       r_state;
  mix_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out_valid;
  logic             r_overrun;
  logic             r_lo_err;
  logic             w_acc_active;
  logic             w_accept;
  logic             w_last;
  logic             w_dump;
  logic             w_load;
  logic             w_clear;

  always_ff @(posedge clk) begin
    if (resetn)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (enable)  w_state_nxt = ACC;
      ACC:     if (!enable) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_acc_active = (r_state == ACC);
  end

  assign w_accept = w_acc_active && in_valid;
  assign w_last   = (r_cnt == CNT_W'(ACC_LEN - 1));
  assign w_dump   = w_accept && w_last;
  // A dump only lands if the output slot is free or being drained this cycle
  assign w_load   = w_dump && (!r_out_valid || out_ready);
  assign w_clear  = !enable;

  always_ff @(posedge clk) begin
    if (resetn)
      r_cnt <= '0;
    else if (w_clear)
      r_cnt <= '0;
    else if (w_accept)
      r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (w_dump) begin
      if (w_load)
        r_out_valid <= 1'b1;
      else
        r_overrun <= 1'b1;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn)
      r_lo_err <= 1'b0;
    else if (w_accept && (lo_cos == c_lo_bad || lo_sin == c_lo_bad))
      r_lo_err <= 1'b1;
  end

  iq_mac_lane #(
    .DATA_W (DATA_W),
    .ACC_LEN(ACC_LEN),
    .OUT_W  (OUT_W)
  ) u_lane_i (
    .clk     (clk),
    .resetn  (resetn),
    .i_clear (w_clear),
    .i_accept(w_accept),
    .i_last  (w_last),
    .i_load  (w_load),
    .i_sample(in_sample),
    .i_lo    (lo_cos),
    .o_result(i_out)
  );

  iq_mac_lane #(
    .DATA_W (DATA_W),
    .ACC_LEN(ACC_LEN),
    .OUT_W  (OUT_W)
  ) u_lane_q (
    .clk     (clk),
    .resetn  (resetn),
    .i_clear (w_clear),
    .i_accept(w_accept),
    .i_last  (w_last),
    .i_load  (w_load),
    .i_sample(in_sample),
    .i_lo    (lo_sin),
    .o_result(q_out)
  );

  assign out_valid = r_out_valid;
  assign overrun   = r_overrun;
  assign lo_err    = r_lo_err;

endmodule

`default_nettype wire

// File: tb/tb_iq_mixer_acc.sv
// ============================================================================
// Module  : tb_iq_mixer_acc
// Brief   : Directed, table-driven bench for iq_mixer_acc (8-bit, 4-sample window)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iq_mixer_acc;

  localparam int DATA_W  = 8;
  localparam int ACC_LEN = 4;
  localparam int OUT_W   = 10;

  logic                     clk;
  logic                     resetn;
  logic                     enable;
  logic signed [DATA_W-1:0] in_sample;
  logic                     in_valid;
  logic signed [1:0]        lo_cos;
  logic signed [1:0]        lo_sin;
  logic signed [OUT_W-1:0]  i_out;
  logic signed [OUT_W-1:0]  q_out;
  logic                     out_valid;
  logic                     out_ready;
  logic                     overrun;
  logic                     lo_err;

  int checks = 0;
  int errors = 0;

  iq_mixer_acc #(
    .DATA_W (DATA_W),
    .ACC_LEN(ACC_LEN),
    .OUT_W  (OUT_W)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .enable   (enable),
    .in_sample(in_sample),
    .in_valid (in_valid),
    .lo_cos   (lo_cos),
    .lo_sin   (lo_sin),
    .i_out    (i_out),
    .q_out    (q_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overrun  (overrun),
    .lo_err   (lo_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic vld;
    int   s;
    int   c;
    int   sn;
    logic rdy;
    logic ev;
    int   ei;
    int   eq;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic vld, input int s, input int c, input int sn,
                              input logic rdy, input logic ev, input int ei, input int eq);
    vec_t v;
    v.vld = vld; v.s = s; v.c = c; v.sn = sn;
    v.rdy = rdy; v.ev = ev; v.ei = ei; v.eq = eq;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  // Apply inputs, clock once, and settle 1 ns past the edge before sampling
  task automatic drive(input logic vld, input int s, input int c, input int sn, input logic rdy);
    in_valid  = vld;
    in_sample = s[DATA_W-1:0];
    lo_cos    = c[1:0];
    lo_sin    = sn[1:0];
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic ev, input int ei, input int eq);
    chk({name, ".valid"}, int'(out_valid), int'(ev));
    if (ev) begin
      chk({name, ".i"}, int'(i_out), ei);
      chk({name, ".q"}, int'(q_out), eq);
    end
  endtask

  initial begin
    int sat_exp;
`ifdef IQ_MIXER_SAT_EN
    sat_exp = 511;
`else
    sat_exp = -512;
`endif

    resetn = 1'b1; enable = 1'b0;
    drive(1'b0, 0, 0, 0, 1'b0);
    drive(1'b1, 33, 1, 1, 1'b0);
    chk("rst.valid", int'(out_valid), 0);
    chk("rst.i", int'(i_out), 0);
    chk("rst.q", int'(q_out), 0);
    chk("rst.overrun", int'(overrun), 0);
    chk("rst.lo_err", int'(lo_err), 0);

    resetn = 1'b0;
    drive(1'b1, 99, 1, 1, 1'b1);
    chk("idle.no_accept", int'(out_valid), 0);
    enable = 1'b1;
    drive(1'b0, 0, 0, 0, 1'b1);

    // Scenario 1: mixed LO phases
    tbl.push_back(mk(1'b1, 10,  1,  0, 1'b1, 1'b0,   0,   0));
    tbl.push_back(mk(1'b1, 20,  0,  1, 1'b1, 1'b0,   0,   0));
    tbl.push_back(mk(1'b1, 30, -1,  0, 1'b1, 1'b0,   0,   0));
    tbl.push_back(mk(1'b1, 40,  0, -1, 1'b1, 1'b1, -20, -20));
    // Scenario 2: two back-to-back full-scale windows
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(1'b1, 127, 1, 0, 1'b1, (k % 4) == 3, 508, 0));
    tbl.push_back(mk(1'b0, 0, 0, 0, 1'b1, 1'b0, 0, 0));

    for (int r = 0; r < tbl.size(); r++) begin
      drive(tbl[r].vld, tbl[r].s, tbl[r].c, tbl[r].sn, tbl[r].rdy);
      chk_out($sformatf("tbl%0d", r), tbl[r].ev, tbl[r].ei, tbl[r].eq);
    end

    // Scenario 4: out_ready raised exactly on the dump cycle
    for (int k = 0; k < 4; k++) drive(1'b1, 3, 1, 0, 1'b0);
    chk_out("s4.first", 1'b1, 12, 0);
    for (int k = 0; k < 3; k++) drive(1'b1, 1, 1, 0, 1'b0);
    chk_out("s4.hold", 1'b1, 12, 0);
    drive(1'b1, 1, 1, 0, 1'b1);
    chk_out("s4.swap", 1'b1, 4, 0);
    chk("s4.overrun", int'(overrun), 0);
    drive(1'b0, 0, 0, 0, 1'b1);
    chk("s4.drain", int'(out_valid), 0);

    // Scenario 5: partial window dropped by enable going low
    drive(1'b1, 7, 1, 0, 1'b1);
    drive(1'b1, 7, 1, 0, 1'b1);
    enable = 1'b0;
    drive(1'b0, 0, 0, 0, 1'b1);
    enable = 1'b1;
    drive(1'b0, 0, 0, 0, 1'b1);
    for (int k = 0; k < 3; k++) drive(1'b1, 5, 1, 0, 1'b1);
    chk("s5.early", int'(out_valid), 0);
    drive(1'b1, 5, 1, 0, 1'b1);
    chk_out("s5.res", 1'b1, 20, 0);
    drive(1'b0, 0, 0, 0, 1'b1);

    // Scenario 6: full-scale negative times -1, then an illegal LO code
    for (int k = 0; k < 4; k++) drive(1'b1, -128, -1, 0, 1'b1);
    chk_out("s6.narrow", 1'b1, sat_exp, 0);
    chk("s6.lo_err0", int'(lo_err), 0);
    drive(1'b1, 100, -2, 1, 1'b1);
    for (int k = 0; k < 3; k++) drive(1'b1, 1, 1, 0, 1'b1);
    chk_out("s6.bad_lo", 1'b1, 3, 100);
    chk("s6.lo_err1", int'(lo_err), 1);
    drive(1'b0, 0, 0, 0, 1'b1);

    // Scenario 3: result held through a lost window
    for (int k = 0; k < 4; k++) drive(1'b1, 1, 1, 0, 1'b0);
    chk_out("s3.first", 1'b1, 4, 0);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2, 1, 0, 1'b0);
      chk_out($sformatf("s3.hold%0d", k), 1'b1, 4, 0);
    end
    chk("s3.overrun", int'(overrun), 1);
    drive(1'b0, 0, 0, 0, 1'b1);
    chk("s3.accepted", int'(out_valid), 0);
    drive(1'b0, 0, 0, 0, 1'b0);
    chk("s3.no_second", int'(out_valid), 0);
    chk("s3.sticky", int'(overrun), 1);

    // Reset with a result pending
    for (int k = 0; k < 4; k++) drive(1'b1, 9, 1, 1, 1'b0);
    chk_out("rst2.pending", 1'b1, 36, 36);
    resetn = 1'b1;
    drive(1'b0, 0, 0, 0, 1'b0);
    chk("rst2.valid", int'(out_valid), 0);
    chk("rst2.i", int'(i_out), 0);
    chk("rst2.overrun", int'(overrun), 0);
    chk("rst2.lo_err", int'(lo_err), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
